// File: rtl/openip_credit_sender.sv
// Credit-based link transmitter: valid/ready in, registered valid/data out.
// Each sent beat spends one credit; the far-end receiver returns them.
module openip_credit_sender #(
    parameter int  DATA_WIDTH = 1,
    parameter type TYPE       = logic [DATA_WIDTH-1:0],
    parameter int  CREDITS    = 4,
    localparam int CREDIT_WIDTH = $clog2(CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  TYPE                     w_data,
    output logic                    tx_valid,
    output TYPE                     tx_data,
    input  logic                    credit_return,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    idle,
    output logic                    overflow
);

    localparam logic [CREDIT_WIDTH-1:0] CREDITS_C = CREDIT_WIDTH'(CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] ONE_C     = CREDIT_WIDTH'(1);

    logic [CREDIT_WIDTH-1:0] credit_q;
    logic [CREDIT_WIDTH-1:0] credit_d;
    logic                    tx_valid_q;
    logic                    tx_valid_d;
    TYPE                     tx_data_q;
    TYPE                     tx_data_d;
    logic                    ovf_q;
    logic                    ovf_d;
    logic                    fire;

    // Ready comes only from the held credit count, never from the return pin.
    always_comb begin
        w_ready = (credit_q != '0);
        fire    = w_valid && w_ready;
    end

    // Next-state: credit accounting, sticky overflow and link beat capture.
    always_comb begin
        credit_d   = credit_q;
        ovf_d      = ovf_q;
        tx_valid_d = fire;
        tx_data_d  = tx_data_q;
        if (fire) begin
            tx_data_d = w_data;
        end
        unique case ({fire, credit_return})
            2'b10: credit_d = credit_q - ONE_C;
            2'b01: begin
                if (credit_q == CREDITS_C) begin
                    ovf_d = 1'b1;
                end else begin
                    credit_d = credit_q + ONE_C;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    // Control state; reset drops any in-flight beat and refills credits.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q   <= CREDITS_C;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // Payload register is unreset; it is meaningless while tx_valid is low.
    always_ff @(posedge clk) begin
        tx_data_q <= tx_data_d;
    end

    // Output mapping and idle detection from registered state.
    always_comb begin
        tx_valid     = tx_valid_q;
        tx_data      = tx_data_q;
        credit_count = credit_q;
        overflow     = ovf_q;
        idle         = (credit_q == CREDITS_C) && !tx_valid_q;
    end

endmodule

// File: tb/tb_openip_credit_sender.sv
// Self-checking bench for openip_credit_sender: directed scenarios plus
// random traffic against an ideal CREDITS-deep receiver model.
module tb_openip_credit_sender;

    localparam int DW = 8;
    localparam int CR = 4;
    localparam int CW = $clog2(CR + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          credit_return;
    logic [CW-1:0] credit_count;
    logic          idle;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    openip_credit_sender #(
        .DATA_WIDTH(DW),
        .CREDITS   (CR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .credit_return(credit_return),
        .credit_count (credit_count),
        .idle         (idle),
        .overflow     (overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        w_valid = 1'b0;
        credit_return = 1'b0;
        w_data = '0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (credit_count !== CW'(CR)) begin
            errors++;
            $display("FAIL reset_count got %0d want %0d", credit_count, CR);
        end
        checks++;
        if (w_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_tx got %b/%b want 1/0", w_ready, tx_valid);
        end
        checks++;
        if (idle !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ovf got %b/%b want 1/0", idle, overflow);
        end
    endtask

    task automatic test_burst();
        logic [DW-1:0] d;
        w_valid = 1'b1;
        for (int i = 0; i < CR; i++) begin
            d = DW'(8'hA + i);
            w_data = d;
            step();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== d) begin
                errors++;
                $display("FAIL burst_beat%0d got v=%b d=%h want v=1 d=%h",
                         i, tx_valid, tx_data, d);
            end
            checks++;
            if (credit_count !== CW'(CR - 1 - i)) begin
                errors++;
                $display("FAIL burst_count%0d got %0d want %0d",
                         i, credit_count, CR - 1 - i);
            end
            checks++;
            if (w_ready !== (i < CR - 1)) begin
                errors++;
                $display("FAIL burst_ready%0d got %b want %b",
                         i, w_ready, (i < CR - 1));
            end
        end
        w_data = 8'hEE;
        step();
        checks++;
        if (tx_valid !== 1'b0 || w_ready !== 1'b0 || credit_count !== '0) begin
            errors++;
            $display("FAIL starved got v=%b r=%b c=%0d want 0/0/0",
                     tx_valid, w_ready, credit_count);
        end
    endtask

    task automatic test_steady();
        logic [DW-1:0] d;
        w_valid = 1'b1;
        credit_return = 1'b1;
        w_data = 8'h0F;
        step();
        checks++;
        if (tx_valid !== 1'b0 || credit_count !== CW'(1)) begin
            errors++;
            $display("FAIL steady_first got v=%b c=%0d want 0/1",
                     tx_valid, credit_count);
        end
        for (int i = 0; i < 5; i++) begin
            d = DW'(8'h10 + i);
            w_data = d;
            step();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== d || credit_count !== CW'(1)) begin
                errors++;
                $display("FAIL steady%0d got v=%b d=%h c=%0d want 1/%h/1",
                         i, tx_valid, tx_data, credit_count, d);
            end
        end
        w_valid = 1'b0;
        credit_return = 1'b0;
        step();
        credit_return = 1'b1;
        for (int i = 0; i < CR - 1; i++) step();
        credit_return = 1'b0;
        checks++;
        if (credit_count !== CW'(CR) || idle !== 1'b1) begin
            errors++;
            $display("FAIL steady_home got c=%0d idle=%b want %0d/1",
                     credit_count, idle, CR);
        end
    endtask

    task automatic test_full_simul();
        w_valid = 1'b1;
        credit_return = 1'b1;
        w_data = 8'h55;
        step();
        w_valid = 1'b0;
        credit_return = 1'b0;
        checks++;
        if (credit_count !== CW'(CR) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_simul got c=%0d ovf=%b want %0d/0",
                     credit_count, overflow, CR);
        end
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
            errors++;
            $display("FAIL full_simul_tx got v=%b d=%h want 1/55",
                     tx_valid, tx_data);
        end
        step();
    endtask

    task automatic test_overflow();
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        checks++;
        if (overflow !== 1'b1 || credit_count !== CW'(CR)) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b c=%0d want 1/%0d",
                     overflow, credit_count, CR);
        end
        step();
        step();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b want 1", overflow);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        w_valid = 1'b1;
        for (int i = 0; i < CR - 1; i++) begin
            w_data = DW'(8'h30 + i);
            step();
        end
        checks++;
        if (credit_count !== CW'(1) || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got c=%0d v=%b want 1/1",
                     credit_count, tx_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        w_valid = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || credit_count !== CW'(CR) || idle !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst got v=%b c=%0d idle=%b want 0/%0d/1",
                     tx_valid, credit_count, idle, CR);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] rx[$];
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] want;
        bit            fly = 1'b0;
        bit            pop;
        bit            acc;
        bit            arrive;
        int            held;
        int            bad = 0;
        for (int n = 0; n < 10000; n++) begin
            held = CR - rx.size() - int'(fly);
            pop = (rx.size() > 0) && ($urandom_range(3) != 0);
            credit_return = pop;
            w_valid = ($urandom_range(2) != 0);
            w_data = DW'($urandom);
            acc = w_valid && (held != 0);
            arrive = fly;
            checks++;
            if (w_ready !== (held != 0) || credit_count !== CW'(held) ||
                idle !== (held == CR && !fly) || overflow !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_state n=%0d got r=%b c=%0d i=%b o=%b want c=%0d",
                             n, w_ready, credit_count, idle, overflow, held);
            end
            checks++;
            if (tx_valid !== fly) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_txv n=%0d got %b want %b", n, tx_valid, fly);
            end
            if (arrive && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if (tx_data !== want) begin
                    errors++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL rand_data n=%0d got %h want %h", n, tx_data, want);
                end
                rx.push_back(tx_data);
            end
            if (acc) exp_q.push_back(w_data);
            step();
            if (pop) void'(rx.pop_front());
            fly = acc;
            checks++;
            if (rx.size() > CR) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_rx_overrun n=%0d got %0d want <=%0d",
                             n, rx.size(), CR);
            end
        end
        w_valid = 1'b0;
        credit_return = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_steady();
        test_full_simul();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
